multicycle_ctrl: RTL
====================

# multicycle_ctrl

Control unit for the multicycle RISC-V datapath, sitting directly upstream of the `alu` block. It sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states. It drives the ALU's 3-bit `Control` code and operand selects, and consumes the ALU's `Zero` flag to resolve `beq`. It covers RV32I `lw`, `sw`, R-type ALU, I-type ALU, `beq` and `jal`.

## Interface
- No parameters.
- `clk` in 1 — single clock; the state register updates on the rising edge.
- `reset` in 1 — asynchronous, active-high. Forces the state to FETCH immediately.
- `op` in 7 — `instr[6:0]` from the instruction register.
- `funct3` in 3 — `instr[14:12]`.
- `funct7b5` in 1 — `instr[30]`.
- `Zero` in 1 — from the ALU; 1 when `Result` == 0.
- `PCWrite` out 1 — load the PC.
- `AdrSrc` out 1 — memory address select: 0 = PC, 1 = ALU result register.
- `MemWrite` out 1 — data memory write strobe.
- `IRWrite` out 1 — load the instruction register and OldPC.
- `ResultSrc` out 2 — result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- `ALUSrcA` out 2 — A operand: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB` out 2 — B operand: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2 — immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `RegWrite` out 1 — register file write enable.
- `ALUControl` out 3 — drives the ALU `Control` input.
- `IllegalOp` out 1 — asserted in DECODE when the opcode is not supported.

## Operation
- The FSM is Moore-style: outputs decode from the state register only. Exceptions:
  - `PCWrite = PCUpdate | (Branch & Zero)`.
  - `ALUControl` and `ImmSrc` are combinational from `op`/`funct3`/`funct7b5`.
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R 0110011
  - I 0010011
  - beq 1100011
  - jal 1101111
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw/sw→MEMADR, R→EXECUTER, I→EXECUTEI, beq→BEQ, jal→JAL, other→FETCH with `IllegalOp`=1.
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER and EXECUTEI→ALUWB.
  - JAL→ALUWB.
  - ALUWB→FETCH.
  - BEQ→FETCH.
- Asserted outputs per state (anything unlisted is 0):
  - FETCH: IRWrite, PCUpdate; ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch/jump target).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: RegWrite; ResultSrc 01.
  - MEMWRITE: MemWrite, AdrSrc 1; ResultSrc 00.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: RegWrite; ResultSrc 00.
  - BEQ: Branch; ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00.
  - JAL: PCUpdate; ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00.
- ALU decode:
  - ALUOp 00 → 000 (add); ALUOp 01 → 001 (sub).
  - ALUOp 10 by funct3:
    - 000: sub if `op[5]&funct7b5`, else add.
    - 010: 101 (slt).
    - 110: 011 (or).
    - 111: 010 (and).
    - other: 000.
  - ALUOp 11 → 000.
- ImmSrc decode: lw/I 00, sw 01, beq 10, jal 11, other 00.

## Timing
- Reset: state = FETCH asynchronously. While `reset` is high, outputs equal FETCH decode (IRWrite=1, PCWrite=1); datapath registers are held in reset by the same signal.
- First instruction: the first rising edge after `reset` deasserts moves the FSM to DECODE.
- Cycles per instruction:
  - lw 5
  - sw, R, I, jal 4
  - beq 3
  - illegal 2
- `Zero` is sampled combinationally in BEQ only. Taken vs not-taken does not change the cycle count.
- Reset asserted mid-instruction aborts it. No MemWrite/RegWrite is issued after the reset edge.
- `op` must be stable from DECODE until the instruction returns to FETCH (the IR is loaded only in FETCH).

## Structure
- Package `riscv_ctrl_pkg` holds:
  - state encoding (11 states, 4-bit)
  - opcode constants
  - ALUOp codes
  - ALU control codes: ADD 000, SUB 001, AND 010, OR 011, SLT 101
  - ResultSrc / ALUSrc / ImmSrc encodings
- One combinational sub-module, `alu_decoder` (ALUOp, funct3, op[5], funct7b5 → ALUControl), instantiated inside `multicycle_ctrl`.
- The FSM next-state and output decode live in the top module.

## Test plan
- Reset then `op`=0110011, funct3=000, funct7b5=1 → states F,D,ER,ALUWB. ALUControl=001 in EXECUTER; RegWrite=1 only in cycle 4; back to FETCH at cycle 5.
- `op`=0000011 (lw) → 5 cycles. AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB. ImmSrc=00 throughout.
- `op`=1100011 with Zero=1 → PCWrite=1 in BEQ, ALUControl=001. With Zero=0 → PCWrite=0 in BEQ. Both cases 3 cycles.
- `op`=0010011, funct3=110 → ALUControl=011 in EXECUTEI, ALUSrcB=01. `op`=0100011 → MemWrite=1 for exactly one cycle in MEMWRITE.
- `op`=1111111 → IllegalOp=1 in DECODE, next state FETCH, no RegWrite/MemWrite.
- Assert `reset` asynchronously in MEMADR of an sw → state FETCH immediately; MemWrite never asserts.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, ALUOp classes, ALU control codes and datapath select values.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's ALUOp class and the
// instruction's funct fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          // only R-type (op5=1) with funct7b5 selects sub; addi never does
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences lw/sw/R/I/beq/jal through
// Fetch..Writeback and drives the datapath selects and ALU control.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
);

  state_t  state;
  state_t  state_next;
  alu_op_t alu_op;
  logic    pc_update;
  logic    branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    IllegalOp  = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    unique case (state)
      S_FETCH: begin
        state_next = S_DECODE;
        IRWrite    = 1'b1;
        pc_update  = 1'b1;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next = S_FETCH;
            IllegalOp  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_LW)      state_next = S_MEMREAD;
        else if (op == OP_SW) state_next = S_MEMWRITE;
        else                  state_next = S_FETCH;
      end
      S_MEMREAD: begin
        state_next = S_MEMWB;
        AdrSrc     = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_DATA;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECUTER: begin
        state_next = S_ALUWB;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        state_next = S_ALUWB;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        branch  = 1'b1;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
      end
      S_JAL: begin
        state_next = S_ALUWB;
        pc_update  = 1'b1;
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);

  always_comb begin
    unique case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule
